// File: rtl/psum_write_buffer_ctrl.sv
// Result write buffer: latches one result (optionally summed with a partial sum),
// stores it in a DEPTH-entry FIFO and reports busy / written / job-complete status.
module psum_write_buffer_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] total_count,
    input  logic                   req,
    input  logic [DATA_WIDTH-1:0]  res_data,
    input  logic                   psum_mode,
    input  logic [DATA_WIDTH-1:0]  psum_data,
    output logic [1:0]             stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] written_count
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]    OCC_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RESP    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   sum;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH-1:0]   rptr;
    logic [ADDR_WIDTH:0]     occupancy;
    logic [COUNT_WIDTH-1:0]  count_next;
    logic                    push;
    logic                    pop;

    assign sum        = psum_mode ? DATA_WIDTH'(res_data + psum_data) : res_data;
    assign full       = (occupancy == OCC_FULL);
    assign empty      = (occupancy == '0);
    assign out_valid  = !empty;
    assign out_data   = mem[rptr];
    // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
    assign push       = (state == PENDING) && !full;
    assign pop        = out_valid && out_ready;
    assign count_next = (written_count == COUNT_MAX) ? written_count : written_count + 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            stall         <= 2'b00;
            word          <= '0;
            wptr          <= '0;
            rptr          <= '0;
            occupancy     <= '0;
            written_count <= '0;
        end else begin
            if (push) begin
                wptr          <= wptr + 1'b1;
                written_count <= count_next;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            case (state)
                IDLE: begin
                    stall <= 2'b00;
                    if (req) begin
                        word  <= sum;
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (!full) begin
                        state <= RESP;
                        stall <= (count_next >= total_count) ? 2'b11 : 2'b10;
                    end else begin
                        stall <= 2'b00;
                    end
                end
                RESP: begin
                    // stall[0] carries the job-complete decision taken at the write.
                    if (stall[0]) begin
                        state <= DONE;
                    end else begin
                        state <= IDLE;
                        stall <= 2'b00;
                    end
                end
                DONE: begin
                    stall <= 2'b11;
                end
                default: begin
                    state <= IDLE;
                    stall <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: doc/psum_write_buffer_ctrl.md
PSUM_WRITE_BUFFER_CTRL -- requirements
Module: psum_write_buffer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, result and output word width.
REQ-002 SHALL have parameter DEPTH, default 8 (power of 2), output buffer entries; ADDR_WIDTH = log2(DEPTH), default 3.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, width of job result counters.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have the port list below, one port per line (name, direction, width, meaning).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  async active-high reset.
- total_count  in  COUNT_WIDTH  results expected for the job; sampled at each write.
- req  in  1  write request pulse, driven by the main controller's done.
- res_data  in  DATA_WIDTH  result value to store.
- psum_mode  in  1  add psum_data to res_data before storing.
- psum_data  in  DATA_WIDTH  partial sum operand.
- stall  out  2  response code: 00 busy, 10 written/more pending, 11 job complete.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  downstream accepts the head word.
- out_data  out  DATA_WIDTH  head word of the buffer.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- written_count  out  COUNT_WIDTH  results written since reset.

Function
REQ-006 SHALL implement the FSM states IDLE, PENDING, RESP and DONE.
REQ-007 In IDLE with req=1, SHALL latch a word and go to PENDING; the word is res_data + psum_data when psum_mode=1, else res_data, truncated to DATA_WIDTH (modulo wrap, no saturation).
REQ-008 In PENDING with full=0, SHALL write the latched word to mem[wptr], increment wptr (wrap DEPTH-1 -> 0), occupancy and written_count, and go to RESP.
REQ-009 In PENDING with full=1, SHALL hold state and the latched word and drive stall=00 until full=0; there is no bypass, even if a pop occurs in the same cycle.
REQ-010 In RESP, SHALL drive stall=10 and return to IDLE when written_count < total_count.
REQ-011 In RESP, SHALL drive stall=11 and go to DONE when written_count >= total_count; total_count=0 gives 11 on the first write.
REQ-012 In DONE, SHALL hold stall=11, ignore req, and keep draining, until reset.
REQ-013 In IDLE and PENDING, SHALL drive stall=00.
REQ-014 SHALL give stall=10 or 11 for exactly one cycle in RESP (DONE excepted), registered from state.
REQ-015 Latency: req sampled at edge E0 and buffer not full -> write at E1 -> stall valid in the cycle after E1 (2 cycles after req).
REQ-016 SHALL ignore req in PENDING, RESP or DONE; no queuing.
REQ-017 SHALL set out_valid = !empty and out_data = mem[rptr] combinationally from registered pointers.
REQ-018 SHALL pop when out_valid & out_ready: increment rptr (wrap) and decrement occupancy.
REQ-019 On a simultaneous write and pop, SHALL leave occupancy unchanged and advance both pointers.
REQ-020 SHALL derive full and empty from an occupancy counter of ADDR_WIDTH+1 bits, so pointer equality is never ambiguous.
REQ-021 SHALL saturate written_count at its maximum; it never wraps.

Reset
REQ-022 On reset, SHALL asynchronously set state=IDLE, stall=00, wptr=rptr=0, occupancy=0 (empty=1, full=0, out_valid=0), written_count=0, and latched word=0.
REQ-023 On reset mid-operation (any state), SHALL discard buffer contents and any pending word; memory array contents need no reset.
REQ-024 After reset, SHALL accept a req in the first cycle.

Verification
REQ-025 Basic write: total_count=3, psum_mode=0, req with res_data=0x0012 -> stall=10 two cycles later for 1 cycle, out_valid=1, out_data=0x0012, written_count=1.
REQ-026 Psum add and wrap: psum_mode=1, res_data=0xFFF0, psum_data=0x0020 -> stored 0x0010; out_data=0x0010.
REQ-027 Job end: total_count=2, two reqs -> stall 10 then 11; 11 held, and a third req is ignored (written_count stays 2).
REQ-028 Full backpressure: DEPTH=8, out_ready=0, 8 writes -> full=1; a 9th req gives stall=00 indefinitely; out_ready=1 for one cycle -> write lands next edge, stall=10, full=1 again.
REQ-029 Wrap and concurrency: continuous out_ready=1 with 20 writes -> output order equals input order, pointers wrap, occupancy never exceeds 1.
REQ-030 Reset in PENDING while full: assert reset -> empty=1, out_valid=0, stall=00, written_count=0 immediately (async).
